// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: latches A, B and a borrow-in, then resolves one
// difference bit per clock LSB-first through a single full-subtractor stage.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic stage_d;
  logic stage_bo;
  logic last_bit;

  assign stage_d  = a_q[0] ^ b_q[0] ^ br_q;
  assign stage_bo = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Difference enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = {stage_d, diff_q[WIDTH-1:1]};
        br_d   = stage_bo;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          bout_d  = stage_bo;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor controller.
- Latches two WIDTH-bit operands and an initial borrow.
- Steps a single-bit full-subtractor stage LSB-first, one bit per clock, holding the borrow in a register between bits.
- Presents the difference and the final borrow with a start/busy/done handshake.
- Used where a cheap, area-minimal subtract is acceptable, e.g. a compare or decrement path in a small datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CW, 5, bit-counter width; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled when start is accepted.
- b  input  WIDTH  subtrahend; sampled when start is accepted.
- bin  input  1  initial borrow-in; sampled when start is accepted.
- busy  output  1  high while in RUN or DONE.
- done  output  1  single-cycle pulse: result valid.
- diff  output  WIDTH  result A - B - bin mod 2**WIDTH; holds until the next accepted start.
- bout  output  1  final borrow-out; 1 iff A < B + bin (unsigned); holds with diff.

Behaviour:
- Per-bit stage, on bits ai, bi and borrow register br:
  - di = ai ^ bi ^ br
  - bo = (~ai & bi) | (~(ai ^ bi) & br)
  - Must be functionally exact; the stage's borrow term is a true AND, not an OR.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - busy=0, done=0.
  - On start=1 at edge k:
    - latch a and b into shift registers;
    - br <= bin;
    - cnt <= 0;
    - diff shift register <= 0;
    - go to RUN.
  - start=0: stay in IDLE; diff and bout hold.
- RUN, each edge:
  - compute the stage on the LSB of the a/b shift regs and br;
  - shift di into the diff register from the MSB side (right shift, so bit 0 ends at position 0 after WIDTH shifts);
  - br <= bo; cnt <= cnt+1.
  - At the edge where cnt == WIDTH-1 (the WIDTH-th bit), also go to DONE.
  - RUN therefore occupies exactly WIDTH cycles: edges k+1 .. k+WIDTH.
- DONE, entered at edge k+WIDTH:
  - done=1 for exactly one cycle; diff final; bout = br.
  - Next edge: go to IDLE unconditionally.
- Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH. Next start can be accepted at the edge that leaves DONE+1 (i.e. once back in IDLE).
- Throughput: one result per WIDTH+2 cycles.
- start is ignored in RUN and DONE (no queueing, no error flag). a, b and bin may change freely after acceptance without effect.
- diff and bout outputs:
  - Registered.
  - During RUN they show the partial shift value; consumers use them only when done=1 or in IDLE after a completed operation.
  - bout updates only on entry to DONE.
- Reset (rst=1 at any edge, any state, including mid-RUN):
  - state <= IDLE;
  - busy=0, done=0, diff=0, bout=0, cnt=0, br=0;
  - the in-flight operation is discarded with no done pulse.
  - rst has priority over start in the same cycle.
- Width rules: result is mod 2**WIDTH; no overflow flag (bout is the unsigned borrow). Two's-complement signed interpretation of diff is the consumer's concern.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, diff=0, bout=0 throughout.
- WIDTH=8, a=0x5A, b=0x23, bin=0, start one cycle:
  - done exactly WIDTH+1 = 9 cycles after the accept edge;
  - diff=0x37, bout=0;
  - busy high for 9 cycles.
- a=0x10, b=0x20, bin=1 -> diff=0xEF, bout=1. Also a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1 (full borrow ripple across all bits).
- Accept a=0x80, b=0x01, then pulse start with other operands at cycles 3 and 9 (RUN and DONE) -> ignored; single done; diff=0x7F, bout=0.
- Assert rst for one cycle at the 4th RUN cycle -> no done pulse, all outputs 0. Then a new start with a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
- Random regression, 1000 ops with back-to-back starts (start held high):
  - each result matches the A-B-bin model;
  - accepts are spaced exactly WIDTH+2 cycles apart.
